// File: rtl/stopwatch_counter_if.sv
// Control inputs and display outputs of the MM:SS stopwatch counter.
// The master side drives the ticks and buttons; the slave side is the counter itself.
interface stopwatch_counter_if;
  logic       tick_1hz;
  logic       tick_adj;
  logic       pause_p;
  logic       adj;
  logic       sel;
  logic [4:0] digit1;
  logic [4:0] digit2;
  logic [4:0] digit3;
  logic [4:0] digit4;
  logic [3:0] blink_mask;
  logic       running;

  modport master (
    output tick_1hz, tick_adj, pause_p, adj, sel,
    input  digit1, digit2, digit3, digit4, blink_mask, running
  );

  modport slave (
    input  tick_1hz, tick_adj, pause_p, adj, sel,
    output digit1, digit2, digit3, digit4, blink_mask, running
  );
endinterface

// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch with run/pause control, manual field adjust and a blink mask
// that marks the field being adjusted on the 4-digit display.
module stopwatch_counter #(
  parameter int MAX_MIN       = 59,
  parameter bit RESET_RUNNING = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_counter_if.slave  sw
);

  typedef enum logic {PAUSED = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MAX_M10 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M1  = 4'(MAX_MIN % 10);

  state_t     state_q, state_d;
  logic [3:0] m10_q, m10_d;
  logic [3:0] m1_q, m1_d;
  logic [3:0] s10_q, s10_d;
  logic [3:0] s1_q, s1_d;
  logic       blink_phase_q, blink_phase_d;
  logic [3:0] blink_mask_q, blink_mask_d;
  logic       count_en;
  logic       sec_inc;
  logic       min_inc;

  always_comb begin
    state_d       = state_q;
    m10_d         = m10_q;
    m1_d          = m1_q;
    s10_d         = s10_q;
    s1_d          = s1_q;
    blink_phase_d = blink_phase_q;
    blink_mask_d  = 4'b0000;

    if (sw.pause_p) begin
      if (state_q == RUN) state_d = PAUSED;
      else                state_d = RUN;
    end

    // Counting uses the registered state, so a tick coinciding with pause still counts.
    count_en = !sw.adj && sw.tick_1hz && (state_q == RUN);
    sec_inc  = count_en || (sw.adj && sw.tick_adj && sw.sel);
    min_inc  = (count_en && s1_q == 4'd9 && s10_q == 4'd5) ||
               (sw.adj && sw.tick_adj && !sw.sel);

    if (sec_inc) begin
      if (s1_q == 4'd9) begin
        s1_d = 4'd0;
        if (s10_q == 4'd5) s10_d = 4'd0;
        else               s10_d = s10_q + 4'd1;
      end else begin
        s1_d = s1_q + 4'd1;
      end
    end

    if (min_inc) begin
      if (m10_q == MAX_M10 && m1_q == MAX_M1) begin
        m10_d = 4'd0;
        m1_d  = 4'd0;
      end else if (m1_q == 4'd9) begin
        m1_d  = 4'd0;
        m10_d = m10_q + 4'd1;
      end else begin
        m1_d  = m1_q + 4'd1;
      end
    end

    if (!sw.adj)          blink_phase_d = 1'b0;
    else if (sw.tick_adj) blink_phase_d = !blink_phase_q;

    if (sw.adj && blink_phase_d) blink_mask_d = sw.sel ? 4'b0011 : 4'b1100;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (RESET_RUNNING) state_q <= RUN;
      else               state_q <= PAUSED;
      m10_q         <= 4'd0;
      m1_q          <= 4'd0;
      s10_q         <= 4'd0;
      s1_q          <= 4'd0;
      blink_phase_q <= 1'b0;
      blink_mask_q  <= 4'b0000;
    end else begin
      state_q       <= state_d;
      m10_q         <= m10_d;
      m1_q          <= m1_d;
      s10_q         <= s10_d;
      s1_q          <= s1_d;
      blink_phase_q <= blink_phase_d;
      blink_mask_q  <= blink_mask_d;
    end
  end

  assign sw.digit1     = {1'b0, m10_q};
  assign sw.digit2     = {1'b0, m1_q};
  assign sw.digit3     = {1'b0, s10_q};
  assign sw.digit4     = {1'b0, s1_q};
  assign sw.blink_mask = blink_mask_q;
  assign sw.running    = (state_q == RUN);

endmodule
